// File: rtl/lsu_m_if.sv
// Data-memory request/grant/response bus between the M-stage LSU and data memory.
// Signal names keep the LSU-side direction suffixes so both ends read the same.
interface lsu_m_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );
endinterface

// File: rtl/lsu_m.sv
// Memory-stage load/store unit: decodes loads/stores, formats data, runs the dmem handshake
// and stalls the front of the pipeline while an access is outstanding.
module lsu_m #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_M_i,
  input  logic [31:0] inst_M_i,
  input  logic [31:0] alu_M_i,
  input  logic [31:0] rs2data_M_i,
  input  logic [4:0]  rdaddr_M_i,
  input  logic        rdwr_M_i,
  output logic [4:0]  rdaddr_M_o,
  output logic        rdwr_M_o,
  output logic [31:0] datareg_M_o,
  output logic [31:0] inst_M_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        err_o,
  lsu_m_if.master     dmem
);

  typedef enum logic [1:0] {StIdle, StReq, StWaitR} state_e;

  localparam logic [31:0] Nop = 32'h0000_0013;

  state_e      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic        r_orphan, w_orphan_nxt;

  logic        w_is_load, w_is_store, w_mem, w_f3_ok, w_misal, w_go;
  logic        w_done, w_timeout, w_req, w_tmo_hit;
  logic [2:0]  w_f3;
  logic [1:0]  w_a;
  logic [31:0] w_shifted, w_ldata;

  assign w_f3       = inst_M_i[14:12];
  assign w_a        = alu_M_i[1:0];
  assign w_is_load  = valid_M_i && (inst_M_i[6:0] == 7'b0000011);
  assign w_is_store = valid_M_i && (inst_M_i[6:0] == 7'b0100011);
  assign w_mem      = w_is_load || w_is_store;

  always_comb begin
    w_f3_ok = 1'b0;
    if (w_is_load) begin
      w_f3_ok = (w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b010) ||
                (w_f3 == 3'b100) || (w_f3 == 3'b101);
    end else if (w_is_store) begin
      w_f3_ok = (w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b010);
    end
  end

  // funct3[1:0] encodes the access size for every legal load/store.
  assign w_misal = w_mem && w_f3_ok &&
                   (((w_f3[1:0] == 2'b01) && w_a[0]) ||
                    ((w_f3[1:0] == 2'b10) && (w_a != 2'b00)));
  assign w_go    = w_mem && w_f3_ok && !w_misal;

  assign w_tmo_hit = (r_cnt == 16'(TIMEOUT_CYCLES));

  always_comb begin
    w_state_nxt  = r_state;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    w_req        = 1'b0;
    w_orphan_nxt = dmem.dmem_rvalid_i ? 1'b0 : r_orphan;
    unique case (r_state)
      StIdle: begin
        if (w_go) begin
          w_req = 1'b1;
          if (!dmem.dmem_gnt_i)  w_state_nxt = StReq;
          else if (w_is_store)   w_done      = 1'b1;
          else                   w_state_nxt = StWaitR;
        end
      end
      StReq: begin
        w_req = 1'b1;
        if (dmem.dmem_gnt_i) begin
          if (w_is_store) begin
            w_done      = 1'b1;
            w_state_nxt = StIdle;
          end else begin
            w_state_nxt = StWaitR;
          end
        end else if (w_tmo_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      StWaitR: begin
        if (dmem.dmem_rvalid_i && !r_orphan) begin
          w_done      = 1'b1;
          w_state_nxt = StIdle;
        end else if (w_tmo_hit) begin
          w_timeout    = 1'b1;
          w_orphan_nxt = 1'b1;
          w_state_nxt  = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
    w_cnt_nxt = ((r_state == StIdle) || (w_state_nxt != r_state)) ? 16'd0 : r_cnt + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= StIdle;
      r_cnt    <= 16'd0;
      r_orphan <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_orphan <= w_orphan_nxt;
    end
  end

  assign w_shifted = dmem.dmem_rdata_i >> {w_a, 3'b000};

  always_comb begin
    unique case (w_f3)
      3'b000:  w_ldata = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_ldata = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_ldata = {24'd0, w_shifted[7:0]};
      3'b101:  w_ldata = {16'd0, w_shifted[15:0]};
      default: w_ldata = w_shifted;
    endcase
  end

  always_comb begin
    dmem.dmem_be_o    = 4'b1111;
    dmem.dmem_wdata_o = rs2data_M_i;
    if (w_is_store) begin
      unique case (w_f3[1:0])
        2'b00: begin
          dmem.dmem_be_o    = 4'b0001 << w_a;
          dmem.dmem_wdata_o = {4{rs2data_M_i[7:0]}};
        end
        2'b01: begin
          dmem.dmem_be_o    = 4'b0011 << w_a;
          dmem.dmem_wdata_o = {2{rs2data_M_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Gating with rst_ni makes an asserted reset drop the request and stall at once.
  assign dmem.dmem_req_o  = rst_ni && w_req;
  assign dmem.dmem_we_o   = w_is_store;
  assign dmem.dmem_addr_o = {alu_M_i[31:2], 2'b00};

  assign stall_o     = rst_ni && w_go && !w_done && !w_timeout;
  assign misalign_o  = rst_ni && w_misal;
  assign err_o       = rst_ni && ((w_mem && !w_f3_ok) || w_timeout);
  assign rdaddr_M_o  = rdaddr_M_i;
  assign rdwr_M_o    = rst_ni && rdwr_M_i && !stall_o && !w_misal && !w_timeout &&
                       !(w_mem && !w_f3_ok);
  assign inst_M_o    = stall_o ? Nop : inst_M_i;
  assign datareg_M_o = (w_go && w_is_load) ? w_ldata : alu_M_i;

endmodule

// File: doc/lsu_m.md
# lsu_M

Memory-stage load/store unit of the 5-stage RV32I pipeline. It takes the instruction, ALU result and store data in M and drives the data-memory request/grant/response handshake. It formats load data (sign/zero extension) and store data (lane replication, byte enables). Its results feed the M/W pipeline register, and it stalls the front of the pipeline while an access is outstanding.

## Interface
- TIMEOUT_CYCLES, 255: cycles an access may wait in REQ or WAIT_R before it is aborted. Legal range 1..65535.
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- valid_M_i  in  1  M holds a real instruction; 0 = bubble
- inst_M_i  in  32  instruction in M
- alu_M_i  in  32  ALU result; the effective address for load/store
- rs2data_M_i  in  32  store source data
- rdaddr_M_i  in  5  destination register
- rdwr_M_i  in  1  register write enable from decode
- rdaddr_M_o  out  5  to M/W register
- rdwr_M_o  out  1  to M/W register
- datareg_M_o  out  32  to M/W register: formatted load data or alu_M_i
- inst_M_o  out  32  to M/W register
- stall_o  out  1  freeze the PC, F/D, D/E and E/M registers
- misalign_o  out  1  misaligned access pulse
- err_o  out  1  timeout or illegal-funct3 pulse
- dmem_req_o  out  1  request
- dmem_we_o  out  1  1 = store
- dmem_addr_o  out  32  {alu_M_i[31:2], 2'b00}
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_gnt_i  in  1  request accepted this cycle
- dmem_rvalid_i  in  1  load data valid; never returned for stores
- dmem_rdata_i  in  32  load data word

## Operation
- Decode:
  - mem op = valid_M_i and opcode 0000011 (load) or 0100011 (store).
  - Load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Store funct3: 000 SB, 001 SH, 010 SW.
  - Any other funct3 is illegal: err_o pulse, no request, rdwr_M_o=0.
- Non-mem op or bubble: outputs pass through; datareg_M_o=alu_M_i; no request, no stall.
- Misaligned access (halfword with a[0]=1; word with a[1:0]≠0): no request, misalign_o=1 for one cycle, rdwr_M_o=0, no stall.
- Store data:
  - SB: wdata={4{rs2[7:0]}}, be=0001<<a[1:0].
  - SH: wdata={2{rs2[15:0]}}, be=0011<<a[1:0].
  - SW: wdata=rs2, be=1111.
  - For loads, be=1111.
- Load data: word shifted right by 8·a[1:0], then sign-extended (LB, LH) or zero-extended (LBU, LHU) from bit 7/15.
- FSM:
  - IDLE: on a legal aligned mem op, dmem_req_o=1 combinationally.
    - gnt=1 with a store: op completes in this cycle.
    - gnt=1 with a load: go to WAIT_R.
    - gnt=0: go to REQ.
  - REQ: req held with addr/we/be/wdata stable. On gnt: store → IDLE (completes); load → WAIT_R.
  - WAIT_R: req=0. On rvalid: op completes, datareg_M_o=formatted data → IDLE.
  - dmem_rvalid_i is ignored in IDLE and REQ.
- stall_o = mem op present and not completing this cycle.
- Stalled cycles: rdwr_M_o=0 and inst_M_o=32'h00000013 (NOP), so a bubble enters M/W. In the completing cycle the real values are driven.
- Upstream holds every M input stable while stall_o=1.
- Timeout:
  - A 16-bit counter clears on entry to REQ or WAIT_R and increments each cycle in those states.
  - When it equals TIMEOUT_CYCLES: → IDLE, err_o pulse, stall_o=0, rdwr_M_o=0.
- Orphan flag:
  - Set on a timeout in WAIT_R; cleared by the next dmem_rvalid_i, which is then discarded.
  - While set, a new load waits in WAIT_R for a second rvalid.

## Timing
- Reset (async assert, sync-released use): state=IDLE, counter=0, orphan=0, dmem_req_o=0, stall_o=0, err_o=0, misalign_o=0, rdwr_M_o=0.
- Reset mid-access drops req immediately. No handshake is resumed after reset.
- Store, zero-wait grant: 1 cycle, no stall.
- Load, gnt at cycle 0 and rvalid at cycle 1: stall_o=1 in cycle 0, data on datareg_M_o in cycle 1, captured by M/W at the end of cycle 1.
- Latency = 1 + grant wait + response wait.
- err_o and misalign_o are single-cycle pulses, combinational in the decision cycle.
- gnt and rvalid in the same cycle while in REQ: the rvalid is ignored. rvalid is never accepted earlier than one cycle after gnt.

## Test plan
- ALU op (add) with alu_M_i=0x1234: no req, stall_o=0, datareg_M_o=0x1234, rdwr_M_o=rdwr_M_i.
- LB at a=0x103, rdata=0x80FF_0000, gnt same cycle, rvalid +1: stall 1 cycle, then datareg_M_o=0xFFFFFF80. LBU at the same address gives 0x00000080.
- SH at a=0x202, rs2=0xABCD1234, gnt delayed 3 cycles: req held 4 cycles with be=1100 and wdata=0x12341234; stall_o=1 for 3 cycles; inst_M_o=NOP and rdwr_M_o=0 while stalled.
- LW at a=0x105: no req, misalign_o=1 for one cycle, rdwr_M_o=0, stall_o=0.
- Load with TIMEOUT_CYCLES=4 and gnt but no rvalid: err_o after 4 WAIT_R cycles. A late rvalid is discarded. The next LW waits for the following rvalid and returns its data.
- rst_ni low while in REQ: dmem_req_o=0 and stall_o=0 immediately; after release the FSM is in IDLE.
